// File: rtl/video_lvds_pkg.sv
// Shared definitions for the 4-lane + clock-lane 7:1 LVDS video link.
// The lane bit positions are common to the transmitter and this receiver.
package video_lvds_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

  localparam int WORD_BITS = 7;
  localparam int NUM_LANES = 4;

  localparam logic [WORD_BITS-1:0] CLK_PATTERN_DEF = 7'b1100011;

  // Bit positions inside a received word; bit 6 is the first bit on the wire.
  // Multi-bit fields run LSB-first from bit 6 downwards (bit-reversed word).
  localparam int L1_RED_LSB  = 6;   // red[5:0]   <- w1[6:1]
  localparam int L1_GRN0     = 0;
  localparam int L2_GRN1     = 6;   // green[5:1] <- w2[6:2]
  localparam int L2_BLU0     = 1;
  localparam int L2_BLU1     = 0;
  localparam int L3_BLU2     = 6;   // blue[5:2]  <- w3[6:3]
  localparam int L3_HSYNC    = 2;
  localparam int L3_VSYNC    = 1;
  localparam int L3_DE       = 0;
  localparam int L4_RED6     = 6;
  localparam int L4_RED7     = 5;
  localparam int L4_GRN6     = 4;
  localparam int L4_GRN7     = 3;
  localparam int L4_BLU6     = 2;
  localparam int L4_BLU7     = 1;
  localparam int L4_DE       = 0;

endpackage

// File: rtl/lvds_word_align.sv
// Clock-lane word aligner: shift register, phase counter and HUNT/VERIFY/LOCKED
// state machine. word_strobe marks an aligned word that should be decoded.
module lvds_word_align
  import video_lvds_pkg::*;
#(
  parameter logic [WORD_BITS-1:0] CLK_PATTERN  = CLK_PATTERN_DEF,
  parameter int                   LOCK_COUNT   = 4,
  parameter int                   UNLOCK_COUNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lane_clk,
  output logic       word_strobe,
  output logic       lock_lost,
  output logic       locked,
  output logic [7:0] align_err_cnt
);

  localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);
  localparam logic [2:0] PH_LAST  = 3'(WORD_BITS - 1);

  lock_state_t          r_state;
  logic [WORD_BITS-1:0] r_sr_clk;
  logic [2:0]           r_ph;
  logic [3:0]           r_match_cnt;
  logic [3:0]           r_miss_cnt;
  logic                 r_locked;
  logic [7:0]           r_align_err_cnt;

  logic w_match;
  logic w_ph0;
  logic w_lock_lost;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_match     = (r_sr_clk == CLK_PATTERN);
  assign w_ph0       = (r_ph == 3'd0);
  // The final miss drops lock on this edge, so that word is not decoded.
  assign w_lock_lost = (r_state == LOCKED) && w_ph0 && !w_match &&
                       (r_miss_cnt + 4'd1 == UNLOCK_N);

  assign word_strobe   = (r_state == LOCKED) && w_ph0 && !w_lock_lost;
  assign lock_lost     = w_lock_lost;
  assign locked        = r_locked;
  assign align_err_cnt = r_align_err_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= HUNT;
      r_sr_clk        <= '0;
      r_ph            <= 3'd0;
      r_match_cnt     <= 4'd0;
      r_miss_cnt      <= 4'd0;
      r_locked        <= 1'b0;
      r_align_err_cnt <= 8'd0;
    end else begin
      r_sr_clk <= {r_sr_clk[WORD_BITS-2:0], lane_clk};
      r_ph     <= (r_ph == PH_LAST) ? 3'd0 : r_ph + 3'd1;
      case (r_state)
        HUNT: begin
          if (w_match) begin
            r_ph        <= 3'd1;
            r_match_cnt <= 4'd1;
            r_miss_cnt  <= 4'd0;
            if (LOCK_N == 4'd1) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
            end else begin
              r_state <= VERIFY;
            end
          end
        end
        VERIFY: begin
          if (w_ph0) begin
            if (w_match) begin
              r_match_cnt <= r_match_cnt + 4'd1;
              if (r_match_cnt + 4'd1 == LOCK_N) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              r_match_cnt <= 4'd0;
              r_state     <= HUNT;
            end
          end
        end
        LOCKED: begin
          if (w_ph0) begin
            if (w_match) begin
              r_miss_cnt <= 4'd0;
            end else if (w_lock_lost) begin
              r_miss_cnt      <= 4'd0;
              r_match_cnt     <= 4'd0;
              r_state         <= HUNT;
              r_locked        <= 1'b0;
              r_align_err_cnt <= sat_inc8(r_align_err_cnt);
            end else begin
              r_miss_cnt <= r_miss_cnt + 4'd1;
            end
          end
        end
        default: begin
          r_state  <= HUNT;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/video_lvds_rx.sv
// 7:1 LVDS video receiver: data-lane shift registers plus RGB888/sync/DE
// decode, registered one clk after each aligned word completes.
module video_lvds_rx
  import video_lvds_pkg::*;
#(
  parameter logic [WORD_BITS-1:0] CLK_PATTERN  = CLK_PATTERN_DEF,
  parameter int                   LOCK_COUNT   = 4,
  parameter int                   UNLOCK_COUNT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lane_clk,
  input  logic [NUM_LANES-1:0] lane_in,
  output logic [7:0]           red,
  output logic [7:0]           green,
  output logic [7:0]           blue,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic                 pixel_valid,
  output logic                 locked,
  output logic                 de_mismatch,
  output logic [7:0]           align_err_cnt
);

  logic                 w_word_strobe;
  logic                 w_lock_lost;
  logic [WORD_BITS-1:0] r_sr  [NUM_LANES];
  logic [WORD_BITS-1:0] w_rev [NUM_LANES];
  logic [7:0]           w_red, w_green, w_blue;
  logic [7:0]           r_red, r_green, r_blue;
  logic                 r_hsync, r_vsync, r_de, r_pixel_valid, r_de_mismatch;

  lvds_word_align #(
    .CLK_PATTERN  (CLK_PATTERN),
    .LOCK_COUNT   (LOCK_COUNT),
    .UNLOCK_COUNT (UNLOCK_COUNT)
  ) u_align (
    .clk           (clk),
    .rst           (rst),
    .lane_clk      (lane_clk),
    .word_strobe   (w_word_strobe),
    .lock_lost     (w_lock_lost),
    .locked        (locked),
    .align_err_cnt (align_err_cnt)
  );

  // Multi-bit fields arrive LSB first, so decode from bit-reversed words.
  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) w_rev[k] = {<<{r_sr[k]}};
    w_red   = {r_sr[3][L4_RED7], r_sr[3][L4_RED6], w_rev[0][5:0]};
    w_green = {r_sr[3][L4_GRN7], r_sr[3][L4_GRN6], w_rev[1][4:0], r_sr[0][L1_GRN0]};
    w_blue  = {r_sr[3][L4_BLU7], r_sr[3][L4_BLU6], w_rev[2][3:0],
               r_sr[1][L2_BLU1], r_sr[1][L2_BLU0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_LANES; k++) r_sr[k] <= '0;
      r_red         <= 8'd0;
      r_green       <= 8'd0;
      r_blue        <= 8'd0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_de          <= 1'b0;
      r_pixel_valid <= 1'b0;
      r_de_mismatch <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_LANES; k++) r_sr[k] <= {r_sr[k][WORD_BITS-2:0], lane_in[k]};
      r_pixel_valid <= w_word_strobe;
      if (w_word_strobe) begin
        r_red   <= w_red;
        r_green <= w_green;
        r_blue  <= w_blue;
        r_hsync <= r_sr[2][L3_HSYNC];
        r_vsync <= r_sr[2][L3_VSYNC];
        r_de    <= r_sr[2][L3_DE];
        if (r_sr[2][L3_DE] != r_sr[3][L4_DE]) r_de_mismatch <= 1'b1;
      end else if (w_lock_lost) begin
        r_de          <= 1'b0;
        r_de_mismatch <= 1'b0;
      end
    end
  end

  assign red         = r_red;
  assign green       = r_green;
  assign blue        = r_blue;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign pixel_valid = r_pixel_valid;
  assign de_mismatch = r_de_mismatch;

endmodule

// File: tb/tb_video_lvds_rx.sv
// Bench for video_lvds_rx: encodes pixels as the transmitter would, streams
// them bit-serially and scores decoded pixels (value and cycle) in order.
module tb_video_lvds_rx;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       de;
  } pix_t;

  typedef struct {
    int   cyc;
    pix_t p;
  } sb_t;

  localparam logic [6:0] GOOD = 7'b1100011;
  localparam logic [6:0] BAD  = 7'b0000000;
  localparam pix_t       ZPIX = '0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lane_clk = 1'b0;
  logic [3:0] lane_in = 4'd0;
  logic [7:0] red, green, blue, align_err_cnt;
  logic       hsync, vsync, de, pixel_valid, locked, de_mismatch;

  int  cyc = 0;
  int  vec_cnt = 0;
  int  err_cnt = 0;
  int  lock_cyc = -1;
  sb_t exp_q[$];
  sb_t obs_q[$];

  video_lvds_rx dut (
    .clk           (clk),
    .rst           (rst),
    .lane_clk      (lane_clk),
    .lane_in       (lane_in),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .hsync         (hsync),
    .vsync         (vsync),
    .de            (de),
    .pixel_valid   (pixel_valid),
    .locked        (locked),
    .de_mismatch   (de_mismatch),
    .align_err_cnt (align_err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    sb_t s;
    if (pixel_valid === 1'b1) begin
      s.cyc = cyc;
      s.p   = {red, green, blue, hsync, vsync, de};
      obs_q.push_back(s);
    end
  end

  // Serialise one 7-bit word per lane, MSB first, as the transmitter does.
  task automatic send_word(input logic [6:0] wc, input pix_t p, input logic de2, input bit expect_pix);
    logic [6:0] w0, w1, w2, w3, c;
    sb_t e;
    w0 = {p.r[0], p.r[1], p.r[2], p.r[3], p.r[4], p.r[5], p.g[0]};
    w1 = {p.g[1], p.g[2], p.g[3], p.g[4], p.g[5], p.b[0], p.b[1]};
    w2 = {p.b[2], p.b[3], p.b[4], p.b[5], p.hs, p.vs, p.de};
    w3 = {p.r[6], p.r[7], p.g[6], p.g[7], p.b[6], p.b[7], de2};
    c  = wc;
    for (int i = 0; i < 7; i++) begin
      lane_clk = c[6];
      lane_in  = {w3[6], w2[6], w1[6], w0[6]};
      c  = c << 1;
      w0 = w0 << 1;
      w1 = w1 << 1;
      w2 = w2 << 1;
      w3 = w3 << 1;
      @(posedge clk);
      #1;
      if (locked === 1'b1 && lock_cyc < 0) lock_cyc = cyc;
    end
    if (expect_pix) begin
      e.cyc = cyc + 1;
      e.p   = p;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle_bit();
    lane_clk = 1'b0;
    lane_in  = 4'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++;
    if ({red, green, blue, hsync, vsync, de, pixel_valid, locked, de_mismatch, align_err_cnt} !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got r=%h g=%h b=%h hs=%b vs=%b de=%b pv=%b lk=%b dm=%b aec=%0d, required all 0",
               red, green, blue, hsync, vsync, de, pixel_valid, locked, de_mismatch, align_err_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_lock_timing();
    int first_cyc;
    lock_cyc = -1;
    send_word(GOOD, ZPIX, 1'b0, 1'b0);
    first_cyc = cyc;
    for (int k = 1; k < 4; k++) send_word(GOOD, ZPIX, 1'b0, 1'b0);
    send_word(GOOD, ZPIX, 1'b0, 1'b1);
    vec_cnt++;
    if (lock_cyc - first_cyc != 22) begin
      err_cnt++;
      $display("FAIL lock_latency: got %0d clks, required 22", lock_cyc - first_cyc);
    end
    vec_cnt++;
    if (locked !== 1'b1) begin
      err_cnt++;
      $display("FAIL lock_state: locked=%b, required 1", locked);
    end
    vec_cnt++;
    if (obs_q.size() != 0) begin
      err_cnt++;
      $display("FAIL lock_no_pixels: got %0d pixels before lock, required 0", obs_q.size());
    end
  endtask

  task automatic test_pixel_decode();
    sb_t  o, e;
    pix_t p;
    send_word(GOOD, '{8'hA5, 8'h3C, 8'hF0, 1'b1, 1'b0, 1'b1}, 1'b1, 1'b1);
    send_word(GOOD, '{8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1}, 1'b1, 1'b1);
    send_word(GOOD, '{8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0}, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      p = pix_t'({$urandom, $urandom});
      send_word(GOOD, p, p.de, 1'b1);
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      vec_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $display("FAIL pix_extra: got %h at cyc %0d, required no pixel", o.p, o.cyc);
      end else begin
        e = exp_q.pop_front();
        if (o.p !== e.p || o.cyc != e.cyc) begin
          err_cnt++;
          $display("FAIL pix_decode: got %h at cyc %0d, required %h at cyc %0d", o.p, o.cyc, e.p, e.cyc);
        end
      end
    end
    vec_cnt++;
    if (exp_q.size() > 1) begin
      err_cnt++;
      $display("FAIL pix_missing: got %0d undelivered pixels, required at most 1 pending", exp_q.size());
    end
  endtask

  task automatic test_de_mismatch();
    sb_t o, e;
    send_word(GOOD, '{8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 1'b1}, 1'b0, 1'b1);
    send_word(GOOD, '{8'h9A, 8'hBC, 8'hDE, 1'b1, 1'b0, 1'b1}, 1'b1, 1'b1);
    vec_cnt++;
    if (de !== 1'b1 || de_mismatch !== 1'b1) begin
      err_cnt++;
      $display("FAIL de_mismatch_set: got de=%b dm=%b, required de=1 dm=1", de, de_mismatch);
    end
    send_word(GOOD, '{8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0}, 1'b0, 1'b1);
    send_word(GOOD, '{8'h04, 8'h05, 8'h06, 1'b0, 1'b0, 1'b0}, 1'b0, 1'b1);
    vec_cnt++;
    if (de !== 1'b0 || de_mismatch !== 1'b1) begin
      err_cnt++;
      $display("FAIL de_mismatch_sticky: got de=%b dm=%b, required de=0 dm=1", de, de_mismatch);
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      vec_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $display("FAIL de_pix_extra: got %h at cyc %0d, required no pixel", o.p, o.cyc);
      end else begin
        e = exp_q.pop_front();
        if (o.p !== e.p || o.cyc != e.cyc) begin
          err_cnt++;
          $display("FAIL de_pix_decode: got %h at cyc %0d, required %h at cyc %0d", o.p, o.cyc, e.p, e.cyc);
        end
      end
    end
  endtask

  task automatic test_loss_of_lock();
    sb_t o, e;
    send_word(BAD, '{8'h11, 8'h22, 8'h33, 1'b0, 1'b1, 1'b1}, 1'b1, 1'b1);
    send_word(BAD, ZPIX, 1'b0, 1'b1);
    vec_cnt++;
    if (locked !== 1'b1 || de_mismatch !== 1'b1) begin
      err_cnt++;
      $display("FAIL loss_two_misses: got locked=%b dm=%b, required locked=1 dm=1", locked, de_mismatch);
    end
    send_word(BAD, ZPIX, 1'b0, 1'b0);
    idle_bit();
    vec_cnt++;
    if ({locked, de, pixel_valid, de_mismatch} !== 4'b0000 || align_err_cnt !== 8'd1) begin
      err_cnt++;
      $display("FAIL loss_of_lock: got lk=%b de=%b pv=%b dm=%b aec=%0d, required 0 0 0 0 aec=1",
               locked, de, pixel_valid, de_mismatch, align_err_cnt);
    end
    for (int k = 0; k < 4; k++) send_word(GOOD, ZPIX, 1'b0, 1'b0);
    send_word(BAD, '{8'h77, 8'h66, 8'h55, 1'b1, 1'b1, 1'b1}, 1'b1, 1'b1);
    send_word(BAD, ZPIX, 1'b0, 1'b1);
    send_word(GOOD, '{8'hC3, 8'h81, 8'h7E, 1'b0, 1'b1, 1'b0}, 1'b0, 1'b1);
    vec_cnt++;
    if (locked !== 1'b1 || align_err_cnt !== 8'd1) begin
      err_cnt++;
      $display("FAIL loss_recover: got locked=%b aec=%0d, required locked=1 aec=1", locked, align_err_cnt);
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      vec_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $display("FAIL loss_pix_extra: got %h at cyc %0d, required no pixel", o.p, o.cyc);
      end else begin
        e = exp_q.pop_front();
        if (o.p !== e.p || o.cyc != e.cyc) begin
          err_cnt++;
          $display("FAIL loss_pix_decode: got %h at cyc %0d, required %h at cyc %0d", o.p, o.cyc, e.p, e.cyc);
        end
      end
    end
  endtask

  task automatic test_saturation();
    sb_t o, e;
    for (int i = 0; i < 259; i++) begin
      if (i > 0) for (int k = 0; k < 4; k++) send_word(GOOD, ZPIX, 1'b0, 1'b0);
      send_word(BAD, ZPIX, 1'b0, 1'b1);
      send_word(BAD, ZPIX, 1'b0, 1'b1);
      send_word(BAD, ZPIX, 1'b0, 1'b0);
      idle_bit();
      if (i == 253) begin
        vec_cnt++;
        if (align_err_cnt !== 8'd255) begin
          err_cnt++;
          $display("FAIL sat_reach: got aec=%0d, required 255", align_err_cnt);
        end
      end
    end
    vec_cnt++;
    if (align_err_cnt !== 8'd255 || locked !== 1'b0) begin
      err_cnt++;
      $display("FAIL sat_hold: got aec=%0d locked=%b, required aec=255 locked=0", align_err_cnt, locked);
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      vec_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $display("FAIL sat_pix_extra: got %h at cyc %0d, required no pixel", o.p, o.cyc);
      end else begin
        e = exp_q.pop_front();
        if (o.p !== e.p || o.cyc != e.cyc) begin
          err_cnt++;
          $display("FAIL sat_pix_decode: got %h at cyc %0d, required %h at cyc %0d", o.p, o.cyc, e.p, e.cyc);
        end
      end
    end
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL sat_pix_missing: got %0d undelivered pixels, required 0", exp_q.size());
    end
  endtask

  task automatic test_misalign();
    sb_t        o, e;
    logic [2:0] junk_clk;
    junk_clk = 3'b010;
    for (int i = 0; i < 3; i++) begin
      lane_clk = junk_clk[2];
      lane_in  = 4'($urandom);
      junk_clk = junk_clk << 1;
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 4; k++) send_word(GOOD, pix_t'({$urandom, $urandom}), 1'b0, 1'b0);
    send_word(GOOD, '{8'h5A, 8'hC3, 8'h0F, 1'b0, 1'b1, 1'b1}, 1'b1, 1'b1);
    send_word(GOOD, '{8'hE7, 8'h18, 8'h99, 1'b1, 1'b0, 1'b1}, 1'b1, 1'b1);
    vec_cnt++;
    if (locked !== 1'b1) begin
      err_cnt++;
      $display("FAIL misalign_lock: locked=%b, required 1", locked);
    end
    vec_cnt++;
    if (obs_q.size() != 1) begin
      err_cnt++;
      $display("FAIL misalign_count: got %0d pixels, required 1", obs_q.size());
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      vec_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $display("FAIL misalign_pix_extra: got %h at cyc %0d, required no pixel", o.p, o.cyc);
      end else begin
        e = exp_q.pop_front();
        if (o.p !== e.p || o.cyc != e.cyc) begin
          err_cnt++;
          $display("FAIL misalign_pix: got %h at cyc %0d, required %h at cyc %0d", o.p, o.cyc, e.p, e.cyc);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    lane_clk = 1'b1;
    lane_in  = 4'hF;
    #2;
    rst = 1'b0;
    #1;
    vec_cnt++;
    if ({red, green, blue, hsync, vsync, de, pixel_valid, locked, de_mismatch, align_err_cnt} !== '0) begin
      err_cnt++;
      $display("FAIL reset_midstream: got r=%h g=%h b=%h hs=%b vs=%b de=%b pv=%b lk=%b dm=%b aec=%0d, required all 0",
               red, green, blue, hsync, vsync, de, pixel_valid, locked, de_mismatch, align_err_cnt);
    end
    repeat (10) @(posedge clk);
    #1;
    vec_cnt++;
    if (locked !== 1'b0 || pixel_valid !== 1'b0 || obs_q.size() != 0) begin
      err_cnt++;
      $display("FAIL reset_hold: got locked=%b pv=%b pixels=%0d, required 0 0 0", locked, pixel_valid, obs_q.size());
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock_timing();
    test_pixel_decode();
    test_de_mismatch();
    test_loss_of_lock();
    test_saturation();
    test_misalign();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
